// File: rtl/fft_reader_pkg.sv
// fft_reader_pkg: shared FSM states, default frame length and bit-reversal helper for the FFT bit-reversed reader
package fft_reader_pkg;
  localparam int ADDR_W_DFLT = 4;
  localparam int N = 2**ADDR_W_DFLT;
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  function automatic logic [15:0] bitrev(input logic [15:0] value, input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (i < width) r[i] = value[width-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_skid_fifo2.sv
// fft_skid_fifo2: 2-entry fall-through FIFO (clk, sclr clear, push/push_data in, pop in, count/head/valid out)
module fft_skid_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head,
  output logic         valid
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (sclr) begin
      mem_q   <= '{default: '0};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign valid = (count_q != 2'd0) || push;
  assign head  = (count_q == 2'd0) ? push_data : mem_q[rd_q];
endmodule

// File: rtl/fft_bitrev_reader.sv
// fft_bitrev_reader: drains one frame in bit-reversed order (clk, sclr, start in; rd_en/rd_addr/rd_data RAM port; out_data/valid/ready/last stream; busy, done)
module fft_bitrev_reader
  import fft_reader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  state_t          state_q, state_d;
  logic [ADDR_W:0] n_q, n_d;
  logic            inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic            pop, issue, fifo_valid;
  logic [1:0]      fifo_count;
  logic [2:0]      occ;
  logic [DATA_W:0] head;
  // occupancy seen by the next returning word: stored + in flight - leaving now
  assign occ   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign pop   = fifo_valid & out_ready;
  assign issue = (state_q == READ) && !n_q[ADDR_W] && (occ < 3'd2);
  always_comb begin
    state_d = state_q == IDLE ? (start ? READ : IDLE) :
              state_q == READ ? ((pop && head[DATA_W]) ? DONE : READ) : IDLE;
    n_d = (state_q == IDLE && start) ? '0 : n_q + {{ADDR_W{1'b0}}, issue};
    inflight_d = issue;
    inflight_last_d = issue && (n_q[ADDR_W-1:0] == '1);
  end
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q         <= IDLE;
      n_q             <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end
  fft_skid_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .sclr      (sclr),
    .push      (inflight_q),
    .push_data ({inflight_last_q, rd_data}),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head),
    .valid     (fifo_valid)
  );
  assign rd_en     = issue;
  assign rd_addr   = issue ? ADDR_W'(bitrev(16'(n_q[ADDR_W-1:0]), ADDR_W)) : '0;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_valid ? head[DATA_W-1:0] : '0;
  assign out_last  = fifo_valid & head[DATA_W];
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
endmodule
